// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instr_fetch_unit                                               |
// | Purpose : Reads the current PC, issues one word read at a time to a      |
// |           handshaked instruction memory and buffers {pc, instr} pairs    |
// |           in a small FIFO feeding IF/ID. pc_hold keeps the PC register   |
// |           frozen until the fetch for the current PC has been captured.   |
// | Options : FETCH_TIMEOUT_EN - adds a watchdog on outstanding reads that   |
// |           abandons a stuck request and raises sticky fetch_error.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int unsigned    N         = 32,
  parameter int unsigned    ADDR_W    = 10,
  parameter logic [N-1:0]   TEXT_BASE = 32'h0040_0000,
  parameter int unsigned    DEPTH     = 2,
  parameter int unsigned    TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      pc_value,
  input  logic              flush,
  input  logic              id_stall,
  output logic              pc_hold,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [N-1:0]      imem_rdata,
  output logic              instr_valid,
  output logic [N-1:0]      instr,
  output logic [N-1:0]      instr_pc,
  output logic              fetch_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N-1:0]        pcl_q, pcl_d;     // PC of the request in flight
  logic                w_push;
  logic                w_pop;

  logic [N-1:0]        mem_pc_q  [DEPTH];
  logic [N-1:0]        mem_ins_q [DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    count_q, count_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]     to_q, to_d;
  logic                err_q, err_d;
`endif

  // Next-state logic: issue when space is guaranteed, wait for ack, and
  // swallow the reply of a request that a flush made stale.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pcl_d   = pcl_q;
    w_push  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < c_DEPTH)) begin
          pcl_d   = pc_value;
          // Low PC bits drop out of the word address; upper bits truncate.
          addr_d  = ADDR_W'(pc_value[N-1:2] - TEXT_BASE[N-1:2]);
          req_d   = 1'b1;
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          w_push  = !flush;
        end else if (flush) begin
          state_d = S_DRAIN;
`ifdef FETCH_TIMEOUT_EN
          to_d    = '0;
        end else if (to_q == c_TO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          to_d    = to_q + TO_W'(1);
`endif
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
        end else if (to_q == c_TO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          to_d    = to_q + TO_W'(1);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM and request registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pcl_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pcl_q   <= pcl_d;
`ifdef FETCH_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign w_pop = (count_q != '0) && !id_stall;

  // FIFO pointer/count next state; flush empties the FIFO over any push/pop.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (w_push) wr_d = wr_q + PTR_W'(1);
      if (w_pop)  rd_d = rd_q + PTR_W'(1);
      if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
      else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by count.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      mem_pc_q[wr_q]  <= pcl_q;
      mem_ins_q[wr_q] <= imem_rdata;
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? mem_ins_q[rd_q] : '0;
  assign instr_pc    = instr_valid ? mem_pc_q[rd_q]  : '0;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  // PC may advance only when its fetch is captured or a redirect is loaded.
  assign pc_hold     = reset | ~(w_push | flush);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_unit                                            |
// | Purpose : Directed and randomised stimulus for instr_fetch_unit with a   |
// |           PC-register model and an expected-instruction queue. Covers    |
// |           FETCH_TIMEOUT_EN when that macro is defined.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_value;
  logic        flush;
  logic        id_stall;
  logic        pc_hold;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_error;

  int          total = 0;
  int          bad   = 0;
  ent_t        sb[$];
  ent_t        pend;
  logic        pend_v = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] fetch_pc = '0;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_value   (pc_value),
    .flush      (flush),
    .id_stall   (id_stall),
    .pc_hold    (pc_hold),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .fetch_error(fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs the caller already set. Checks the FIFO
  // head against the queue, models the PC register, then advances the edge.
  task automatic tick(input int hold_exp = -1);
    logic hold;
    logic do_pop;
    #1;
    hold = pc_hold;
    if (hold_exp >= 0) chk("pc_hold", pc_hold, hold_exp);
    chk("instr_valid", instr_valid, sb.size() != 0);
    do_pop = 1'b0;
    if (instr_valid === 1'b1 && id_stall == 1'b0) begin
      do_pop = 1'b1;
      if (sb.size() != 0) begin
        chk("instr", instr, sb[0].ins);
        chk("instr_pc", instr_pc, sb[0].pc);
      end
    end
    @(posedge clk);
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
      if (pend_v) sb.push_back(pend);
    end
    pend_v = 1'b0;
    if (reset)      pc_value = BASE;
    else if (flush) pc_value = flush_pc;
    else if (!hold) pc_value = pc_value + 32'd4;
    #1;
    imem_ack = 1'b0;
    flush    = 1'b0;
  endtask

  // Acknowledge the outstanding read; an accepted ack must release the PC.
  task automatic ack_cycle(input logic [31:0] data, input logic accept);
    imem_ack   = 1'b1;
    imem_rdata = data;
    if (accept) begin
      pend   = '{pc: fetch_pc, ins: data};
      pend_v = 1'b1;
    end
    tick(accept ? 0 : 1);
  endtask

  // Run cycles until a request appears (bounded), then check its address.
  task automatic wait_req(input int budget);
    logic [31:0] off;
    for (int k = 0; k < budget && imem_req !== 1'b1; k++) tick(1);
    chk("req_seen", imem_req, 1'b1);
    fetch_pc = pc_value;
    off = pc_value - BASE;
    chk("imem_addr", imem_addr, off[11:2]);
  endtask

  initial begin
    reset      = 1'b1;
    pc_value   = BASE;
    flush      = 1'b0;
    id_stall   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;

    // Reset held for two cycles.
    @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_addr", imem_addr, 10'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_err", fetch_error, 1'b0);
    tick(1);
    reset = 1'b0;
    chk("rel_req", imem_req, 1'b0);
    tick(1);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 10'd0);
    fetch_pc = pc_value;

    // Ack on the second WAIT cycle.
    tick(1);
    chk("wait_req_held", imem_req, 1'b1);
    ack_cycle(32'h2008_0005, 1'b1);
    chk("valid_after_ack", instr_valid, 1'b1);
    chk("instr_after_ack", instr, 32'h2008_0005);
    chk("pc_after_ack", instr_pc, BASE);
    chk("req_after_ack", imem_req, 1'b0);

    // Stall downstream: FIFO fills, fetching stops until pops free space.
    id_stall = 1'b1;
    wait_req(3);
    chk("second_addr", imem_addr, 10'd1);
    ack_cycle(32'h0000_1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("full_no_req", imem_req, 1'b0);
    end
    chk("full_head_pc", instr_pc, BASE);
    id_stall = 1'b0;
    wait_req(6);
    chk("resume_addr", imem_addr, 10'd2);

    // Flush while waiting without ack; the late reply is dropped.
    flush    = 1'b1;
    flush_pc = BASE + 32'h40;
    tick(0);
    chk("drain_valid", instr_valid, 1'b0);
    chk("drain_req", imem_req, 1'b1);
    tick(1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick(1);
    chk("drain_done_req", imem_req, 1'b0);
    chk("drain_done_valid", instr_valid, 1'b0);
    wait_req(3);
    chk("redirect_addr", imem_addr, 10'h010);

    // Flush coinciding with ack and a pending pop.
    id_stall = 1'b1;
    ack_cycle(32'hAAAA_0001, 1'b1);
    wait_req(3);
    id_stall   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBBBB_0002;
    flush      = 1'b1;
    flush_pc   = BASE + 32'h80;
    tick(0);
    chk("fa_valid", instr_valid, 1'b0);
    chk("fa_req", imem_req, 1'b0);
    tick(1);
    chk("fa_idle_issue", imem_req, 1'b1);
    chk("fa_addr", imem_addr, 10'h020);
    fetch_pc = pc_value;

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no ack for 16 WAIT cycles.
    for (int k = 0; k < 15; k++) tick(1);
    chk("to_err_early", fetch_error, 1'b0);
    chk("to_req_early", imem_req, 1'b1);
    tick(1);
    chk("to_err", fetch_error, 1'b1);
    chk("to_req_drop", imem_req, 1'b0);
    chk("to_valid", instr_valid, 1'b0);
    wait_req(3);
    chk("to_refetch_addr", imem_addr, 10'h020);
    ack_cycle(32'hCCCC_0003, 1'b1);
    chk("to_err_sticky", fetch_error, 1'b1);
`else
    // Without the watchdog a silent memory just keeps the request up.
    for (int k = 0; k < 20; k++) tick(1);
    chk("nw_req", imem_req, 1'b1);
    chk("nw_err", fetch_error, 1'b0);
    ack_cycle(32'hCCCC_0003, 1'b1);
`endif

    // Random latency and stall pattern.
    for (int i = 0; i < 24; i++) begin
      id_stall = 1'b0;
      wait_req(10);
      repeat ($urandom_range(0, 3)) begin
        id_stall = 1'($urandom_range(0, 1));
        tick(1);
      end
      id_stall = 1'($urandom_range(0, 1));
      ack_cycle($urandom, 1'b1);
    end
    id_stall = 1'b0;

    // Reset during WAIT with a late ack in the reset cycle.
    wait_req(10);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick(1);
    chk("rw_req", imem_req, 1'b0);
    chk("rw_valid", instr_valid, 1'b0);
    chk("rw_instr", instr, 32'd0);
    chk("rw_err", fetch_error, 1'b0);
    reset = 1'b0;
    tick(1);
    chk("rw_reissue", imem_req, 1'b1);
    chk("rw_addr", imem_addr, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
